fpmult_dot_accum: RTL and testbench

//   Downstream stage of the fixed-point iterative multiplier: consumes its product stream over val/rdy.

---
 rtl/fpmult_dot_accum.sv | 102 ++++++++++
 tb/tb_fpmult_dot_accum.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpmult_dot_accum.sv
// Dot-product accumulator behind the iterative multiplier: sums K signed products
// into a widened accumulator and hands out one saturated N-bit result per K products.
module fpmult_dot_accum #(
    parameter int N = 32,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         recv_val,
    output logic         recv_rdy,
    input  logic [N-1:0] recv_msg,
    output logic         send_val,
    input  logic         send_rdy,
    output logic [N-1:0] send_msg,
    output logic         send_ovf
);

    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam int AW = N + CW;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   acc_q;
    logic [CW-1:0]   count_q;
    logic            recv_rdy_q;
    logic            send_val_q;
    logic [N-1:0]    send_msg_q;
    logic            send_ovf_q;

    logic            fire;
    logic [AW-1:0]   sum_d;
    logic [CW:0]     sum_top;
    logic            sat_ovf_d;
    logic [N-1:0]    sat_msg_d;

    assign fire = recv_val & recv_rdy_q;

    // The sum fits in N bits exactly when bits [AW-1:N-1] are all copies of the sign.
    always_comb begin
        sum_d     = acc_q + {{CW{recv_msg[N-1]}}, recv_msg};
        sum_top   = sum_d[AW-1:N-1];
        sat_ovf_d = ~((&sum_top) | ~(|sum_top));
        sat_msg_d = sum_d[N-1:0];
        if (sat_ovf_d) begin
            sat_msg_d = sum_d[AW-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ACC;
            acc_q      <= '0;
            count_q    <= '0;
            recv_rdy_q <= 1'b1;
            send_val_q <= 1'b0;
            send_msg_q <= '0;
            send_ovf_q <= 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (fire) begin
                        acc_q <= sum_d;
                        if (count_q == LAST) begin
                            count_q    <= '0;
                            state_q    <= DONE;
                            recv_rdy_q <= 1'b0;
                            send_val_q <= 1'b1;
                            send_msg_q <= sat_msg_d;
                            send_ovf_q <= sat_ovf_d;
                        end else begin
                            count_q <= count_q + CW'(1);
                        end
                    end
                end
                DONE: begin
                    if (send_rdy) begin
                        state_q    <= ACC;
                        acc_q      <= '0;
                        recv_rdy_q <= 1'b1;
                        send_val_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ACC;
                    recv_rdy_q <= 1'b1;
                    send_val_q <= 1'b0;
                end
            endcase
        end
    end

    assign recv_rdy = recv_rdy_q;
    assign send_val = send_val_q;
    assign send_msg = send_msg_q;
    assign send_ovf = send_ovf_q;

endmodule

// File: tb/tb_fpmult_dot_accum.sv
// Bench for fpmult_dot_accum: a K=4 and a K=1 instance checked against a
// scoreboard of clamped sums pushed as products are accepted.
module tb_fpmult_dot_accum;

    logic        clk = 1'b0;
    logic        reset;
    logic        rv4, rr4, sv4, sr4, so4;
    logic [31:0] rm4, sm4;
    logic        rv1, rr1, sv1, sr1, so1;
    logic [31:0] rm1, sm1;

    always #5 clk = ~clk;

    fpmult_dot_accum #(.N(32), .K(4)) dut4 (
        .clk(clk), .reset(reset),
        .recv_val(rv4), .recv_rdy(rr4), .recv_msg(rm4),
        .send_val(sv4), .send_rdy(sr4), .send_msg(sm4), .send_ovf(so4)
    );

    fpmult_dot_accum #(.N(32), .K(1)) dut1 (
        .clk(clk), .reset(reset),
        .recv_val(rv1), .recv_rdy(rr1), .recv_msg(rm1),
        .send_val(sv1), .send_rdy(sr1), .send_msg(sm1), .send_ovf(so1)
    );

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    longint      acc4;
    int          cnt4;
    logic [32:0] q4[$];
    logic [32:0] q1[$];
    logic [32:0] obs4, exp4, obs1, exp1;
    bit          has4, has1;

    function automatic logic [32:0] clampf(input longint a);
        logic [63:0] bits;
        bits = a;
        if (a > 64'sd2147483647) return {1'b1, 32'h7FFFFFFF};
        if (a < -64'sd2147483648) return {1'b1, 32'h80000000};
        return {1'b0, bits[31:0]};
    endfunction

    function automatic logic [31:0] rnd_prod();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 1) == 1) r = {{12{r[19]}}, r[19:0]};
        return r;
    endfunction

    // One clock: observe send handshakes and model accepted products, then advance.
    task automatic step(output bit g4, output bit g1);
        @(negedge clk);
        g4 = !reset && sv4 && sr4;
        g1 = !reset && sv1 && sr1;
        if (g4) begin
            obs4 = {so4, sm4};
            has4 = (q4.size() > 0);
            exp4 = '0;
            if (has4) exp4 = q4.pop_front();
        end
        if (g1) begin
            obs1 = {so1, sm1};
            has1 = (q1.size() > 0);
            exp1 = '0;
            if (has1) exp1 = q1.pop_front();
        end
        if (!reset && rv4 && rr4) begin
            acc4 += longint'($signed(rm4));
            cnt4++;
            if (cnt4 == 4) begin
                q4.push_back(clampf(acc4));
                acc4 = 0;
                cnt4 = 0;
            end
        end
        if (!reset && rv1 && rr1) q1.push_back(clampf(longint'($signed(rm1))));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        bit g4, g1;
        reset = 1'b1;
        rv4 = 1'b0; rv1 = 1'b0; sr4 = 1'b0; sr1 = 1'b0;
        step(g4, g1);
        step(g4, g1);
        reset = 1'b0;
        acc4 = 0; cnt4 = 0;
        q4.delete();
        q1.delete();
    endtask

    task automatic feed4(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d);
        logic [31:0] v[4];
        bit g4, g1;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 0; i < 4; i++) begin
            rv4 = 1'b1;
            rm4 = v[i];
            step(g4, g1);
        end
        rv4 = 1'b0;
    endtask

    task automatic wait_result4(output bit ok);
        bit g4, g1;
        ok = 1'b0;
        sr4 = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            step(g4, g1);
            if (g4) ok = 1'b1;
        end
        sr4 = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rr4 !== 1'b1) begin failures++; $display("FAIL reset_recv_rdy: got %b expected 1", rr4); end
        checks++; if (sv4 !== 1'b0) begin failures++; $display("FAIL reset_send_val: got %b expected 0", sv4); end
        checks++; if (sm4 !== 32'h0) begin failures++; $display("FAIL reset_send_msg: got %h expected 00000000", sm4); end
        checks++; if (so4 !== 1'b0) begin failures++; $display("FAIL reset_send_ovf: got %b expected 0", so4); end
        checks++; if ({rr1, sv1, so1, sm1} !== {3'b100, 32'h0}) begin
            failures++; $display("FAIL reset_k1: got %b%b%b/%h expected 100/00000000", rr1, sv1, so1, sm1);
        end
        $display("test_reset: done");
    endtask

    task automatic test_sum();
        logic [31:0] v[4];
        bit g4, g1, ok;
        do_reset();
        v[0] = 32'h00010000; v[1] = 32'h00020000; v[2] = 32'hFFFF0000; v[3] = 32'h00008000;
        for (int i = 0; i < 4; i++) begin
            rv4 = 1'b1;
            rm4 = v[i];
            checks++; if (sv4 !== 1'b0) begin failures++; $display("FAIL sum_early_val: got %b expected 0 before fire %0d", sv4, i); end
            step(g4, g1);
        end
        rv4 = 1'b0;
        checks++; if (sv4 !== 1'b1) begin failures++; $display("FAIL sum_latency: send_val got %b expected 1", sv4); end
        wait_result4(ok);
        checks++; if (!ok || !has4) begin failures++; $display("FAIL sum_result: got none expected one result"); end
        checks++; if (obs4 !== exp4) begin failures++; $display("FAIL sum_model: got %h expected %h", obs4, exp4); end
        checks++; if (obs4 !== {1'b0, 32'h00028000}) begin failures++; $display("FAIL sum_value: got %h expected 000028000", obs4); end
        $display("test_sum: send_msg=%h ovf=%b", obs4[31:0], obs4[32]);
    endtask

    task automatic test_saturate();
        bit ok;
        do_reset();
        feed4(32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000);
        wait_result4(ok);
        checks++; if (!ok || obs4 !== exp4) begin failures++; $display("FAIL sat_pos_model: got %h expected %h", obs4, exp4); end
        checks++; if (obs4 !== {1'b1, 32'h7FFFFFFF}) begin failures++; $display("FAIL sat_pos: got %h expected 17FFFFFFF", obs4); end
        $display("test_saturate: pos send_msg=%h ovf=%b", obs4[31:0], obs4[32]);
        feed4(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000);
        wait_result4(ok);
        checks++; if (!ok || obs4 !== exp4) begin failures++; $display("FAIL sat_neg_model: got %h expected %h", obs4, exp4); end
        checks++; if (obs4 !== {1'b1, 32'h80000000}) begin failures++; $display("FAIL sat_neg: got %h expected 180000000", obs4); end
        $display("test_saturate: neg send_msg=%h ovf=%b", obs4[31:0], obs4[32]);
    endtask

    task automatic test_backpressure();
        bit g4, g1, ok;
        do_reset();
        feed4(32'h00010000, 32'h00020000, 32'hFFFF0000, 32'h00008000);
        sr4 = 1'b0;
        rv4 = 1'b1;
        rm4 = 32'h12345678;
        for (int i = 0; i < 5; i++) begin
            step(g4, g1);
            checks++; if (sv4 !== 1'b1) begin failures++; $display("FAIL bp_val: got %b expected 1 (cycle %0d)", sv4, i); end
            checks++; if (rr4 !== 1'b0) begin failures++; $display("FAIL bp_rdy: got %b expected 0 (cycle %0d)", rr4, i); end
            checks++; if ({so4, sm4} !== {1'b0, 32'h00028000}) begin
                failures++; $display("FAIL bp_msg: got %h expected 000028000 (cycle %0d)", {so4, sm4}, i);
            end
        end
        rv4 = 1'b0;
        wait_result4(ok);
        checks++; if (!ok || obs4 !== {1'b0, 32'h00028000}) begin failures++; $display("FAIL bp_result: got %h expected 000028000", obs4); end
        // A swallowed product would show up in the next sum of zeros.
        feed4(32'h0, 32'h0, 32'h0, 32'h0);
        wait_result4(ok);
        checks++; if (!ok || obs4 !== {1'b0, 32'h0} || obs4 !== exp4) begin
            failures++; $display("FAIL bp_no_consume: got %h expected 000000000", obs4);
        end
        $display("test_backpressure: done");
    endtask

    task automatic test_reset_mid();
        bit g4, g1, ok;
        do_reset();
        rv4 = 1'b1;
        rm4 = 32'h00050000;
        step(g4, g1);
        step(g4, g1);
        do_reset();
        checks++; if (rr4 !== 1'b1 || sv4 !== 1'b0) begin failures++; $display("FAIL rst_mid_state: got rdy=%b val=%b expected 1/0", rr4, sv4); end
        feed4(32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000);
        wait_result4(ok);
        checks++; if (!ok || obs4 !== {1'b0, 32'h00040000} || obs4 !== exp4) begin
            failures++; $display("FAIL rst_mid_sum: got %h expected 000040000", obs4);
        end
        $display("test_reset_mid: send_msg=%h", obs4[31:0]);
    endtask

    task automatic test_gaps();
        bit g4, g1, ok;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            rv4 = (i % 3 == 0);
            rm4 = rv4 ? 32'(32'h00010000 * (i / 3 + 1)) : 32'(32'hDEAD0000 + i);
            step(g4, g1);
        end
        rv4 = 1'b0;
        wait_result4(ok);
        checks++; if (!ok || obs4 !== exp4) begin failures++; $display("FAIL gaps_model: got %h expected %h", obs4, exp4); end
        checks++; if (obs4 !== {1'b0, 32'h000A0000}) begin failures++; $display("FAIL gaps_value: got %h expected 0000A0000", obs4); end
        $display("test_gaps: send_msg=%h", obs4[31:0]);
    endtask

    task automatic test_streaming();
        bit g4, g1;
        int last4, last1, n4, n1;
        do_reset();
        last4 = -1; last1 = -1; n4 = 0; n1 = 0;
        sr4 = 1'b1;
        sr1 = 1'b1;
        for (int i = 0; i < 66; i++) begin
            rv4 = (i < 60);
            rv1 = (i < 60);
            rm4 = rnd_prod();
            rm1 = rnd_prod();
            step(g4, g1);
            if (g4) begin
                n4++;
                checks++; if (!has4 || obs4 !== exp4) begin failures++; $display("FAIL stream_k4: got %h expected %h", obs4, exp4); end
                if (last4 >= 0) begin
                    checks++; if (cyc - 1 - last4 !== 5) begin failures++; $display("FAIL stream_k4_rate: got %0d expected 5", cyc - 1 - last4); end
                end
                last4 = cyc - 1;
            end
            if (g1) begin
                n1++;
                checks++; if (!has1 || obs1 !== exp1) begin failures++; $display("FAIL stream_k1: got %h expected %h", obs1, exp1); end
                if (last1 >= 0 && i < 61) begin
                    checks++; if (cyc - 1 - last1 !== 2) begin failures++; $display("FAIL stream_k1_rate: got %0d expected 2", cyc - 1 - last1); end
                end
                last1 = cyc - 1;
            end
        end
        sr4 = 1'b0;
        sr1 = 1'b0;
        checks++; if (n4 !== 12 || q4.size() !== 0) begin failures++; $display("FAIL stream_k4_count: got %0d expected 12", n4); end
        checks++; if (n1 !== 30 || q1.size() !== 0) begin failures++; $display("FAIL stream_k1_count: got %0d expected 30", n1); end
        $display("test_streaming: k4 results=%0d k1 results=%0d", n4, n1);
    endtask

    initial begin
        reset = 1'b1;
        rv4 = 1'b0; rm4 = '0; sr4 = 1'b0;
        rv1 = 1'b0; rm1 = '0; sr1 = 1'b0;
        acc4 = 0; cnt4 = 0;
        test_reset();
        test_sum();
        test_saturate();
        test_backpressure();
        test_reset_mid();
        test_gaps();
        test_streaming();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
